// File: rtl/apb_master_engine.sv
// APB3 initiator: turns a single-outstanding command/response handshake into
// SETUP/ACCESS bus cycles, with PREADY wait states, PSLVERR and an optional timeout.
module apb_master_engine #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value held during the last permitted PREADY-low cycle; the abort
  // is decided on that cycle so ACCESS lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          to_hit;

  assign to_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            PSEL      <= 1'b1;
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            if (to_hit) begin
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_valid   <= 1'b1;
              PSEL        <= 1'b0;
              PENABLE     <= 1'b0;
              state       <= RESP;
            end
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_engine.sv
// Randomised scoreboard bench for apb_master_engine with an in-bench APB slave.
module tb_apb_master_engine;
  localparam int AW = 8, DW = 32, TO = 16;

  logic          PCLK = 1'b0, PRESETN = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0, PSLVERR = 1'b0;

  apb_master_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; int waits; logic err; logic [DW-1:0] rd; } plan_t;
  typedef struct { logic [DW-1:0] rd; logic err; logic to; int cyc; } exp_t;

  plan_t planq[$];
  exp_t  expq[$];
  plan_t act;
  int    cyc = 0, acnt = 0, proto_err = 0;
  int    n_chk = 0, n_pass = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // Slave model plus monitor: pops the bus plan at SETUP and the expected response on rsp_valid.
  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      if (planq.size() == 0) proto_err++;
      else act = planq.pop_front();
      acnt = 0;
    end
    if (PENABLE && !PSEL) proto_err++;
    if (PSEL) begin
      chk("paddr", PADDR, act.a);
      chk("pwrite", PWRITE, act.w);
      if (act.w) chk("pwdata", PWDATA, act.d);
    end
    if (PSEL && PENABLE) begin
      if (acnt == act.waits) begin
        PREADY = 1'b1; PRDATA = act.rd; PSLVERR = act.err;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
      acnt++;
    end else begin
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
    end
    if (rsp_valid) begin
      if (expq.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = expq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_timeout", rsp_timeout, e.to);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic do_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic err, input logic [DW-1:0] rd,
                        input bit keep_valid, input bit want_rsp);
    int n = 0;
    plan_t p;
    exp_t  e;
    bit    to;
    int    eff;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin @(negedge PCLK); n++; end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    p.w = w; p.a = a; p.d = d; p.waits = waits; p.err = err; p.rd = rd;
    planq.push_back(p);
    // Reference: a slave stalling TO or more cycles is abandoned after TO access cycles.
    to  = (TO != 0) && (waits >= TO);
    eff = to ? TO - 1 : waits;
    e.rd  = (!w && !to) ? rd : '0;
    e.err = to ? 1'b1 : err;
    e.to  = to;
    e.cyc = cyc + 3 + eff;
    if (want_rsp) expq.push_back(e);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = keep_valid;
    cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 300) begin @(negedge PCLK); n++; end
    chk("drain", expq.size(), 0);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", {rsp_err, rsp_timeout}, 0);
    chk("rst_paddr", PADDR, 0);
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    @(negedge PCLK);
    chk("rst_cmd_ready", cmd_ready, 1);

    do_txn(1, 8'h04, 32'h0000_03E8, 0, 0, 32'h0, 0, 1);
    chk("setup_penable", {PSEL, PENABLE}, 2'b10);
    @(negedge PCLK);
    chk("access_penable", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    chk("resp_cmd_ready", cmd_ready, 0);
    @(negedge PCLK);
    chk("next_cmd_ready", cmd_ready, 1);

    do_txn(0, 8'h08, 32'h0, 3, 0, 32'hDEAD_BEEF, 0, 1);
    drain();
    do_txn(1, 8'h10, 32'h1234_5678, 0, 1, 32'h0, 0, 1);
    drain();
    do_txn(0, 8'h14, 32'h0, 100, 0, 32'h5555_AAAA, 0, 1);
    drain();
    do_txn(0, 8'h18, 32'h0, TO - 1, 0, 32'hCAFE_F00D, 0, 1);
    drain();

    // Valid held high across three commands; the engine alone paces acceptance.
    do_txn(1, 8'h20, 32'hA1, 0, 0, 32'h0, 1, 1);
    do_txn(0, 8'h24, 32'h0, 0, 0, 32'hB2B2_B2B2, 1, 1);
    do_txn(1, 8'h28, 32'hC3, 1, 0, 32'h0, 0, 1);
    drain();

    do_txn(0, 8'h30, 32'h0, 50, 0, 32'h0, 0, 0);
    repeat (4) @(negedge PCLK);
    #2 PRESETN = 1'b0;
    #1;
    chk("async_rst_psel", {PSEL, PENABLE}, 2'b00);
    chk("async_rst_rsp", rsp_valid, 0);
    @(negedge PCLK);
    PRESETN = 1'b1;
    @(negedge PCLK);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge PCLK);
    do_txn(0, 8'h34, 32'h0, 2, 0, 32'h0BAD_F00D, 0, 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      int r, wt;
      r = $urandom_range(0, 9);
      if (r < 6) wt = $urandom_range(0, 3);
      else if (r < 8) wt = $urandom_range(TO - 1, TO);
      else wt = TO + 4;
      do_txn(1'($urandom), AW'($urandom), $urandom, wt, 1'($urandom), $urandom,
             1'($urandom), 1);
    end
    drain();
    chk("protocol", proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
